// File: rtl/sign_result_decoder_if.sv
// Handshake bundle for sign_result_decoder: upstream result stream in, decoded display values out.
interface sign_result_decoder_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sign;
  logic [DATA_W-1:0]     out_mag;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_bcd, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_bcd, out_zero
  );
endinterface

// File: rtl/sign_result_decoder.sv
// Decodes a signed two's-complement result into sign, magnitude and BCD digits (double-dabble).
// Optional SEG7_EN adds a registered active-low 7-segment output with leading-zero blanking.
//
// state | meaning
// IDLE  | ready for a new result
// ABS   | form |in_data| and clear the BCD register
// CONV  | one add-3/shift step per cycle, DATA_W steps
// DONE  | decoded outputs valid, waiting for out_ready
module sign_result_decoder #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic Clear_n,
  sign_result_decoder_if.slave bus
`ifdef SEG7_EN
  ,
  output logic [7*(DIGITS+1)-1:0] seg_n
`endif
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  typedef enum logic [1:0] {IDLE, ABS, CONV, DONE} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] data_r, mag_r, shift_r, abs_val, out_mag_r;
  logic [BCD_W-1:0]  bcd_r, bcd_adj, bcd_next, out_bcd_r;
  logic [CNT_W-1:0]  cnt;
  logic              sign_r, out_sign_r, out_zero_r;
  logic              accept, last_shift;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign last_shift = (state_q == CONV) && (cnt == LAST);
  // Most-negative input wraps to 2^(DATA_W-1), which is still a valid unsigned magnitude.
  assign abs_val    = sign_r ? (~data_r + ONE) : data_r;

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ABS;
      ABS:     state_d = CONV;
      CONV:    if (cnt == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_next = {bcd_adj[BCD_W-2:0], shift_r[DATA_W-1]};

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      data_r     <= '0;
      sign_r     <= 1'b0;
      mag_r      <= '0;
      shift_r    <= '0;
      bcd_r      <= '0;
      cnt        <= '0;
      out_sign_r <= 1'b0;
      out_mag_r  <= '0;
      out_bcd_r  <= '0;
      out_zero_r <= 1'b0;
    end else begin
      if (accept) begin
        data_r <= bus.in_data;
        sign_r <= bus.in_data[DATA_W-1];
      end
      if (state_q == ABS) begin
        mag_r   <= abs_val;
        shift_r <= abs_val;
        bcd_r   <= '0;
        cnt     <= '0;
      end
      if (state_q == CONV) begin
        bcd_r   <= bcd_next;
        shift_r <= shift_r << 1;
        cnt     <= cnt + CNT_ONE;
      end
      if (last_shift) begin
        out_sign_r <= sign_r;
        out_mag_r  <= mag_r;
        out_bcd_r  <= bcd_next;
        out_zero_r <= (mag_r == '0);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sign  = out_sign_r;
  assign bus.out_mag   = out_mag_r;
  assign bus.out_bcd   = out_bcd_r;
  assign bus.out_zero  = out_zero_r;

`ifdef SEG7_EN
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [7*(DIGITS+1)-1:0] seg_d;
  logic                    lead;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = ~7'h3F;
      4'd1:    seg_enc = ~7'h06;
      4'd2:    seg_enc = ~7'h5B;
      4'd3:    seg_enc = ~7'h4F;
      4'd4:    seg_enc = ~7'h66;
      4'd5:    seg_enc = ~7'h6D;
      4'd6:    seg_enc = ~7'h7D;
      4'd7:    seg_enc = ~7'h07;
      4'd8:    seg_enc = ~7'h7F;
      4'd9:    seg_enc = ~7'h6F;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  // Walk from the most significant digit down; blank until the first nonzero digit or the ones digit.
  always_comb begin
    seg_d = '1;
    lead  = 1'b1;
    seg_d[7*(DIGITS+1)-1 -: 7] = sign_r ? SEG_MINUS : SEG_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((bcd_next[4*i +: 4] != 4'd0) || (i == 0)) lead = 1'b0;
      seg_d[7*i +: 7] = lead ? SEG_BLANK : seg_enc(bcd_next[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n)        seg_n <= '1;
    else if (last_shift) seg_n <= seg_d;
  end
`endif
endmodule

// File: tb/tb_sign_result_decoder.sv
// Scoreboard bench for sign_result_decoder: directed vectors, monitor pops expectations on out_valid.
module tb_sign_result_decoder;
  logic clk = 1'b0;
  logic Clear_n;
  int   cyc = 0;

  sign_result_decoder_if #(.DATA_W(8), .DIGITS(3)) bus ();

`ifdef SEG7_EN
  logic [27:0] seg_n;
  sign_result_decoder #(.DATA_W(8), .DIGITS(3)) dut (
    .clk(clk), .Clear_n(Clear_n), .bus(bus), .seg_n(seg_n));
`else
  sign_result_decoder #(.DATA_W(8), .DIGITS(3)) dut (
    .clk(clk), .Clear_n(Clear_n), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sign;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic        zero;
    int          acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   rise_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: all comparisons are evaluated here, both scoreboard pops and posted direct checks.
  exp_t cur;
  logic have = 1'b0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      chk(c.name, c.act, c.exp);
    end
    if (bus.out_valid) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) begin
          have = 1'b0;
          chk("unexpected_output", 32'(bus.out_mag), 32'hFFFF_FFFF);
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          rise_q.push_back(cyc);
          chk("latency", 32'(cyc - cur.acc), 32'd9);
        end
      end
      if (have) begin
        chk("out_sign", 32'(bus.out_sign), 32'(cur.sign));
        chk("out_mag",  32'(bus.out_mag),  32'(cur.mag));
        chk("out_bcd",  32'(bus.out_bcd),  32'(cur.bcd));
        chk("out_zero", 32'(bus.out_zero), 32'(cur.zero));
      end
    end
    prev_v = bus.out_valid;
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
  task automatic send(input logic [7:0] d, input logic s, input logic [7:0] m,
                      input logic [11:0] b, input logic z, input logic push);
    int n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      post("timeout_in_ready", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back('{s, m, b, z, cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    post("drain_done", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Clear_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #3;
    post("rst_in_ready",  32'(bus.in_ready),  32'd1);
    post("rst_out_valid", 32'(bus.out_valid), 32'd0);
    post("rst_out_sign",  32'(bus.out_sign),  32'd0);
    post("rst_out_mag",   32'(bus.out_mag),   32'd0);
    post("rst_out_bcd",   32'(bus.out_bcd),   32'd0);
    post("rst_out_zero",  32'(bus.out_zero),  32'd0);
    repeat (2) @(negedge clk);
    Clear_n = 1'b1;
    @(negedge clk);

    send(8'h80, 1'b1, 8'd128, 12'h128, 1'b0, 1'b1);
    send(8'h7F, 1'b0, 8'd127, 12'h127, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 8'd1,   12'h001, 1'b0, 1'b1);
    send(8'h00, 1'b0, 8'd0,   12'h000, 1'b1, 1'b1);
    drain();

    // Backpressure: hold DONE for 5 cycles while a stray request is offered.
    bus.out_ready = 1'b0;
    send(8'hD6, 1'b1, 8'd42, 12'h042, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    post("bp_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      post("bp_in_ready",  32'(bus.in_ready),  32'd0);
      post("bp_out_valid", 32'(bus.out_valid), 32'd1);
      if (i == 1) begin
        bus.in_data  = 8'h05;
        bus.in_valid = 1'b1;
      end
      if (i == 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    post("bp_release_valid", 32'(bus.out_valid), 32'd0);
    post("bp_release_ready", 32'(bus.in_ready),  32'd1);
    repeat (15) @(negedge clk);
    post("bp_stray_ignored", 32'(exp_q.size()), 32'd0);

    send(8'h0C, 1'b0, 8'd12, 12'h012, 1'b0, 1'b1);
    send(8'hF4, 1'b1, 8'd12, 12'h012, 1'b0, 1'b1);
    drain();
    if (rise_q.size() >= 2)
      post("b2b_spacing", 32'(rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2]), 32'd11);
    else
      post("b2b_spacing", 32'(rise_q.size()), 32'd2);
`ifdef SEG7_EN
    post("seg_minus12", 32'(seg_n), 32'({7'b0111111, 7'b1111111, 7'b1111001, 7'b0100100}));
`endif

    // Reset in the middle of a conversion: immediate idle, and nothing emerges afterwards.
    send(8'h33, 1'b0, 8'd51, 12'h051, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 Clear_n = 1'b0;
    #1;
    post("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    post("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    post("midrst_out_sign",  32'(bus.out_sign),  32'd0);
    post("midrst_out_bcd",   32'(bus.out_bcd),   32'd0);
    post("midrst_out_mag",   32'(bus.out_mag),   32'd0);
    @(negedge clk);
    Clear_n = 1'b1;
    repeat (20) @(negedge clk);
    post("midrst_no_output", 32'(bus.out_valid), 32'd0);
    post("queue_empty",      32'(exp_q.size()),  32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
